// File: rtl/module_dmem_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | module_dmem_ctrl : memory-stage load/store to req/ack bus bridge, stalls   |
// |                    the pipeline while a bus access is outstanding          |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module module_dmem_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemReadM_i,
  input  logic              MemWriteM_i,
  input  logic [2:0]        funct3M_i,
  input  logic [31:0]       ALUResultM_i,
  input  logic [31:0]       WriteDataM_i,
  output logic [31:0]       ReadDataM_o,
  output logic              StallM_o,
  output logic              misaligned_o,
  output logic              bus_err_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_ack_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int c_CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? c_CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit c_TO_EN = (TIMEOUT_CYCLES > 0);

  state_t              r_state;
  logic [c_CNT_W-1:0]  r_cnt;
  logic [2:0]          r_funct3;
  logic [1:0]          r_off;
  logic                r_req;
  logic                r_we;
  logic                r_err;
  logic [ADDR_W-1:0]   r_addr;
  logic [3:0]          r_be;
  logic [31:0]         r_wdata;
  logic [31:0]         r_rdata;

  logic                w_access;
  logic                w_f3_legal;
  logic                w_misal;
  logic                w_ok;
  logic                w_bad;
  logic                w_timeout;
  logic [3:0]          w_be;
  logic [31:0]         w_wdata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [31:0]         w_load;
  logic [ADDR_W-1:0]   w_word_addr;

  assign w_access    = MemReadM_i | MemWriteM_i;
  assign w_word_addr = ADDR_W'({ALUResultM_i[31:2], 2'b00});

  // A simultaneous read+write request is a store, so store rules apply.
  always_comb begin
    w_f3_legal = 1'b0;
    if (MemWriteM_i) begin
      w_f3_legal = !funct3M_i[2] && (funct3M_i[1:0] != 2'b11);
    end else begin
      w_f3_legal = (funct3M_i[1:0] != 2'b11) && !(funct3M_i[2] && funct3M_i[1]);
    end
  end

  always_comb begin
    w_misal = 1'b0;
    case (funct3M_i[1:0])
      2'b01:   w_misal = ALUResultM_i[0];
      2'b10:   w_misal = (ALUResultM_i[1:0] != 2'b00);
      default: w_misal = 1'b0;
    endcase
  end

  assign w_ok  = w_access && w_f3_legal && !w_misal;
  assign w_bad = (r_state == S_IDLE) && w_access && !w_ok;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = WriteDataM_i;
    case (funct3M_i[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUResultM_i[1:0];
        w_wdata = {4{WriteDataM_i[7:0]}};
      end
      2'b01: begin
        w_be    = ALUResultM_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{WriteDataM_i[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM_i;
      end
    endcase
  end

  always_comb begin
    w_byte = bus_rdata_i[7:0];
    case (r_off)
      2'b00:   w_byte = bus_rdata_i[7:0];
      2'b01:   w_byte = bus_rdata_i[15:8];
      2'b10:   w_byte = bus_rdata_i[23:16];
      default: w_byte = bus_rdata_i[31:24];
    endcase
    w_half = r_off[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = bus_rdata_i;
    endcase
  end

  assign w_timeout = c_TO_EN && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_be     <= 4'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ok) begin
            r_state  <= S_WAIT;
            r_cnt    <= '0;
            r_req    <= 1'b1;
            r_we     <= MemWriteM_i;
            r_addr   <= w_word_addr;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_funct3 <= funct3M_i;
            r_off    <= ALUResultM_i[1:0];
          end
        end
        S_WAIT: begin
          // Ack is tested first so it wins over a timeout expiring in the same cycle.
          if (bus_ack_i) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_rdata <= r_we ? 32'd0 : w_load;
          end else if (w_timeout) begin
            r_state <= S_DONE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b1;
            r_rdata <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Combinational outputs are gated by reset so they drop the moment reset asserts.
  assign StallM_o     = rst_i && (((r_state == S_IDLE) && w_ok) || (r_state == S_WAIT));
  assign misaligned_o = rst_i && w_bad;
  assign ReadDataM_o  = w_bad ? 32'd0 : r_rdata;
  assign bus_err_o    = r_err;
  assign bus_req_o    = r_req;
  assign bus_we_o     = r_we;
  assign bus_addr_o   = r_addr;
  assign bus_be_o     = r_be;
  assign bus_wdata_o  = r_wdata;

endmodule
`default_nettype wire
